// File: rtl/svpcie_pkg.sv
// Shared types for the svpcie BAR0 target: completion status codes and the
// pending-read queue entry layout.
package svpcie_pkg;

    localparam int TAG_W   = 8;
    localparam int REQID_W = 16;

    typedef enum logic [2:0] {
        CPL_SC = 3'b000,
        CPL_UR = 3'b001
    } cpl_status_e;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [REQID_W-1:0] req_id;
        logic [6:0]         lower_addr;
        cpl_status_e        status;
        logic [31:0]        data;
    } rdq_entry_t;

endpackage

// File: rtl/svpcie_rdq.sv
// Synchronous FIFO of pending read completions; head is presented directly
// from storage, count/full/empty come straight from registers.
module svpcie_rdq
    import svpcie_pkg::*;
#(
    parameter int  DEPTH = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  rdq_entry_t    push_data,
    input  logic          pop,
    output rdq_entry_t    head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    rdq_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/svpcie_sim.sv
// BAR0 target: 1-DW MWr/MRd to a dword register file, in-order completions.
// SVPCIE_UR_COUNT_EN adds a saturating ur_count output of all UR requests.
module svpcie_sim
    import svpcie_pkg::*;
#(
    parameter int MEM_DWORDS = 256,
    parameter int RDQ_DEPTH  = 32,
    parameter int ADDR_W     = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                rx_is_write,
    input  logic [ADDR_W-1:0]   rx_addr,
    input  logic [9:0]          rx_len_dw,
    input  logic [TAG_W-1:0]    rx_tag,
    input  logic [REQID_W-1:0]  rx_req_id,
    input  logic [31:0]         rx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [TAG_W-1:0]    tx_tag,
    output logic [REQID_W-1:0]  tx_req_id,
    output logic [2:0]          tx_status,
    output logic [31:0]         tx_data,
    output logic [6:0]          tx_lower_addr,
    output logic                cpl_err_ur_p,
`ifdef SVPCIE_UR_COUNT_EN
    output logic [15:0]         ur_count,
`endif
    output logic                cpl_err_ur_np
);

    localparam int                IDX_W     = $clog2(MEM_DWORDS);
    localparam int                CW        = $clog2(RDQ_DEPTH + 1);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(4 * MEM_DWORDS);

    logic [31:0]      rf [MEM_DWORDS];
    logic [IDX_W-1:0] idx;
    logic             supported;
    logic             accept;
    logic             stg_valid;
    rdq_entry_t       stg_entry;
    rdq_entry_t       rdq_head;
    logic             rdq_full;
    logic             rdq_empty;
    logic [CW-1:0]    rdq_count;

    assign supported = (rx_addr[1:0] == 2'b00) && (rx_len_dw == 10'd1) && (rx_addr < MEM_BYTES);
    assign idx       = rx_addr[IDX_W+1:2];

    // The staged read already owns a FIFO slot, so count it against capacity.
    assign rx_ready = !(rdq_full || (stg_valid && rdq_count == CW'(RDQ_DEPTH - 1)));
    assign accept   = rx_valid && rx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_DWORDS; i++) rf[i] <= '0;
        end else if (accept && rx_is_write && supported) begin
            rf[idx] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_valid     <= 1'b0;
            stg_entry     <= '0;
            cpl_err_ur_p  <= 1'b0;
            cpl_err_ur_np <= 1'b0;
        end else begin
            stg_valid     <= accept && !rx_is_write;
            cpl_err_ur_p  <= accept && rx_is_write && !supported;
            cpl_err_ur_np <= accept && !rx_is_write && !supported;
            if (accept && !rx_is_write) begin
                stg_entry.tag        <= rx_tag;
                stg_entry.req_id     <= rx_req_id;
                stg_entry.lower_addr <= rx_addr[6:0];
                stg_entry.status     <= supported ? CPL_SC : CPL_UR;
                stg_entry.data       <= supported ? rf[idx] : 32'h0;
            end
        end
    end

`ifdef SVPCIE_UR_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ur_count <= '0;
        else if (accept && !supported && ur_count != 16'hFFFF)
            ur_count <= ur_count + 16'd1;
    end
`endif

    svpcie_rdq #(.DEPTH(RDQ_DEPTH)) u_rdq (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (stg_valid),
        .push_data (stg_entry),
        .pop       (tx_ready),
        .head      (rdq_head),
        .full      (rdq_full),
        .empty     (rdq_empty),
        .count     (rdq_count)
    );

    assign tx_valid      = !rdq_empty;
    assign tx_tag        = rdq_head.tag;
    assign tx_req_id     = rdq_head.req_id;
    assign tx_status     = rdq_head.status;
    assign tx_data       = rdq_head.data;
    assign tx_lower_addr = rdq_head.lower_addr;

endmodule

// File: tb/tb_svpcie_sim.sv
// Directed bench for svpcie_sim: UR strobes, read-after-write, ordering,
// back-pressure at full queue, and reset flush.
module tb_svpcie_sim;
    import svpcie_pkg::*;

    localparam logic [15:0] RID = 16'hBEEF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        rx_is_write = 1'b0;
    logic [31:0] rx_addr = '0;
    logic [9:0]  rx_len_dw = 10'd1;
    logic [7:0]  rx_tag = '0;
    logic [15:0] rx_req_id = RID;
    logic [31:0] rx_data = '0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_tag;
    logic [15:0] tx_req_id;
    logic [2:0]  tx_status;
    logic [31:0] tx_data;
    logic [6:0]  tx_lower_addr;
    logic        cpl_err_ur_p;
    logic        cpl_err_ur_np;
`ifdef SVPCIE_UR_COUNT_EN
    logic [15:0] ur_count;
`endif

    int checks = 0;
    int errors = 0;
    int p_cnt = 0;
    int np_cnt = 0;
    int acc_cnt = 0;
    rdq_entry_t cq [$];

    always #5 clk = ~clk;

    svpcie_sim dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_is_write   (rx_is_write),
        .rx_addr       (rx_addr),
        .rx_len_dw     (rx_len_dw),
        .rx_tag        (rx_tag),
        .rx_req_id     (rx_req_id),
        .rx_data       (rx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_tag        (tx_tag),
        .tx_req_id     (tx_req_id),
        .tx_status     (tx_status),
        .tx_data       (tx_data),
        .tx_lower_addr (tx_lower_addr),
        .cpl_err_ur_p  (cpl_err_ur_p),
`ifdef SVPCIE_UR_COUNT_EN
        .ur_count      (ur_count),
`endif
        .cpl_err_ur_np (cpl_err_ur_np)
    );

    // Monitors sample mid-cycle; handshakes seen here complete on the next rising edge.
    always @(negedge clk) begin
        rdq_entry_t e;
        if (cpl_err_ur_p)  p_cnt++;
        if (cpl_err_ur_np) np_cnt++;
        if (rx_valid && rx_ready) acc_cnt++;
        if (tx_valid && tx_ready) begin
            e.tag        = tx_tag;
            e.req_id     = tx_req_id;
            e.lower_addr = tx_lower_addr;
            e.status     = cpl_status_e'(tx_status);
            e.data       = tx_data;
            cq.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [31:0] addr, input logic [9:0] len,
                        input logic [7:0] tag, input logic [31:0] d);
        int n = 0;
        rx_is_write = wr;
        rx_addr     = addr;
        rx_len_dw   = len;
        rx_tag      = tag;
        rx_req_id   = RID;
        rx_data     = d;
        rx_valid    = 1'b1;
        while (!rx_ready && n < 400) begin
            cyc(1);
            n++;
        end
        if (!rx_ready) begin
            chk("send_timeout", 32'(n), 32'd0);
            rx_valid = 1'b0;
            return;
        end
        cyc(1);
        rx_valid = 1'b0;
    endtask

    task automatic wait_cq(input string nm, input int n);
        int k = 0;
        while (cq.size() < n && k < 500) begin
            cyc(1);
            k++;
        end
        chk(nm, 32'(cq.size()), 32'(n));
    endtask

    task automatic expect_cpl(input string nm, input logic [7:0] tg, input logic [2:0] st,
                              input logic [31:0] d, input logic [31:0] addr);
        rdq_entry_t e;
        wait_cq({nm, "_cnt"}, 1);
        if (cq.size() == 0) return;
        e = cq.pop_front();
        chk({nm, "_tag"},    32'(e.tag), 32'(tg));
        chk({nm, "_status"}, 32'(e.status), 32'(st));
        chk({nm, "_data"},   e.data, d);
        chk({nm, "_lower"},  32'(e.lower_addr), 32'(addr[6:0]));
        chk({nm, "_reqid"},  32'(e.req_id), 32'(RID));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        logic [31:0] exp_d;
        rdq_entry_t e;

        cyc(3);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_ur_p",     32'(cpl_err_ur_p), 32'd0);
        chk("rst_ur_np",    32'(cpl_err_ur_np), 32'd0);
`ifdef SVPCIE_UR_COUNT_EN
        chk("rst_ur_count", 32'(ur_count), 32'd0);
`endif
        reset_n = 1'b1;
        cyc(2);

        // Unaligned MWr: rejected, no write lands at dword 3.
        tx_ready = 1'b1;
        p_cnt = 0; np_cnt = 0;
        send(1'b1, 32'd14, 10'd1, 8'h00, 32'h1337);
        cyc(3);
        chk("mwr14_ur_p",  32'(p_cnt), 32'd1);
        chk("mwr14_ur_np", 32'(np_cnt), 32'd0);
        send(1'b0, 32'd12, 10'd1, 8'h05, 32'h0);
        expect_cpl("rd12", 8'h05, 3'b000, 32'h0, 32'd12);

        // Unaligned MRd: UR completion, 2-cycle latency visible on tx_*.
        cq.delete();
        tx_ready = 1'b0;
        p_cnt = 0; np_cnt = 0;
        send(1'b0, 32'd14, 10'd1, 8'h2A, 32'h0);
        chk("lat_1cyc_valid", 32'(tx_valid), 32'd0);
        cyc(1);
        chk("lat_2cyc_valid", 32'(tx_valid), 32'd1);
        chk("mrd14_tag",    32'(tx_tag), 32'h2A);
        chk("mrd14_status", 32'(tx_status), 32'd1);
        chk("mrd14_data",   tx_data, 32'h0);
        chk("mrd14_lower",  32'(tx_lower_addr), 32'd14);
        cyc(2);
        chk("mrd14_ur_np", 32'(np_cnt), 32'd1);
        chk("mrd14_ur_p",  32'(p_cnt), 32'd0);
        tx_ready = 1'b1;
        cyc(2);
        chk("mrd14_drained", 32'(tx_valid), 32'd0);
        cq.delete();

        // Length and range boundaries.
        send(1'b0, 32'd0, 10'd2, 8'h10, 32'h0);
        expect_cpl("len2", 8'h10, 3'b001, 32'h0, 32'd0);
        send(1'b0, 32'd1024, 10'd1, 8'h11, 32'h0);
        expect_cpl("addr1024", 8'h11, 3'b001, 32'h0, 32'd1024);
        send(1'b0, 32'd1020, 10'd1, 8'h12, 32'h0);
        expect_cpl("addr1020", 8'h12, 3'b000, 32'h0, 32'd1020);

        send(1'b1, 32'd512, 10'd1, 8'h00, 32'hDEADBEEF);
        send(1'b0, 32'd512, 10'd1, 8'h20, 32'h0);
        expect_cpl("rd512", 8'h20, 3'b000, 32'hDEADBEEF, 32'd512);
`ifdef SVPCIE_UR_COUNT_EN
        chk("ur_count_4", 32'(ur_count), 32'd4);
`endif

        // Fill dwords 0..30, then 31 back-to-back reads.
        for (int i = 0; i < 31; i++) send(1'b1, 32'(i * 4), 10'd1, 8'h00, 32'(i * 4));
        cq.delete();
        for (int i = 0; i < 31; i++) send(1'b0, 32'(i * 4), 10'd1, 8'(i), 32'h0);
        wait_cq("seq31_cnt", 31);
        for (int i = 0; i < 31 && cq.size() > 0; i++) begin
            e = cq.pop_front();
            chk($sformatf("seq31_tag_%0d", i),  32'(e.tag), 32'(i));
            chk($sformatf("seq31_data_%0d", i), e.data, 32'(i * 4));
        end

        // Back-pressure: 32 reads pending, 33rd held off until the queue drains.
        cq.delete();
        tx_ready = 1'b0;
        acc0 = acc_cnt;
        for (int i = 0; i < 32; i++) send(1'b0, 32'(i * 4), 10'd1, 8'(100 + i), 32'h0);
        chk("full_rx_ready", 32'(rx_ready), 32'd0);
        fork
            send(1'b0, 32'd128, 10'd1, 8'd132, 32'h0);
        join_none
        cyc(5);
        chk("full_accepts", 32'(acc_cnt - acc0), 32'd32);
        chk("full_held",    32'(rx_ready), 32'd0);
        tx_ready = 1'b1;
        wait_cq("full_drain_cnt", 33);
        for (int i = 0; i < 33 && cq.size() > 0; i++) begin
            e = cq.pop_front();
            exp_d = (i < 31) ? 32'(i * 4) : 32'h0;
            chk($sformatf("full_tag_%0d", i),  32'(e.tag), 32'(100 + i));
            chk($sformatf("full_data_%0d", i), e.data, exp_d);
        end
        cyc(2);

        // Reset with reads pending: immediate flush, register file cleared.
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b0, 32'd512, 10'd1, 8'(200 + i), 32'h0);
        cyc(2);
        chk("prerst_tx_valid", 32'(tx_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_flush_tx_valid", 32'(tx_valid), 32'd0);
        cyc(2);
        cq.delete();
        reset_n = 1'b1;
        tx_ready = 1'b1;
        cyc(10);
        chk("rst_no_cpl", 32'(cq.size()), 32'd0);
        chk("rst_rx_ready_after", 32'(rx_ready), 32'd1);
`ifdef SVPCIE_UR_COUNT_EN
        chk("rst_ur_count_after", 32'(ur_count), 32'd0);
`endif
        send(1'b0, 32'd512, 10'd1, 8'h33, 32'h0);
        expect_cpl("rd512_after_rst", 8'h33, 3'b000, 32'h0, 32'd512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
